// File: rtl/bky_pkg.sv
// bky_pkg: shared types and constants for the Buckeye chain loader.
//   state_t   - loader FSM states
//   PASSES    - shift passes per load (2 when BKY_READBACK_CHK_EN is defined,
//               the second pass re-sends the image for read-back compare)
//   BKY_DFLT_* - default parameter values for the loader
// Configuration macro: BKY_READBACK_CHK_EN
package bky_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_PRE,
        ST_SHIFT,
        ST_POST
    } state_t;

`ifdef BKY_READBACK_CHK_EN
    localparam int PASSES = 2;
`else
    localparam int PASSES = 1;
`endif

    localparam int BKY_DFLT_WIDTH = 16;
    localparam int BKY_DFLT_DEPTH = 512;
    localparam int BKY_DFLT_DIV   = 20;    // 40 MHz / (2*20) = 1 MHz SHCK
    localparam int BKY_DFLT_WORDS = 18;    // 6 chips x 48 bits

endpackage

// File: rtl/bky_word_buf.sv
// bky_word_buf: append-only configuration word buffer.
// Writes append at COUNT; reads are indexed so loading never consumes data.
// Ports:
//   clk, rst_n     - clock, async active-low reset (clears count only)
//   clr            - empty the buffer (wins over we)
//   we, wdata      - append a word; ignored when full
//   rd_idx/rd_data - combinational indexed read port
//   count          - words held
//   full           - count == DEPTH
module bky_word_buf #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 512,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             we,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];

    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_idx];

    // Storage carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (we && !clr && !full)
            mem[count[AW-1:0]] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (we && !full)
            count <= count + 1'b1;
    end

endmodule

// File: rtl/bky_chain_loader.sv
// bky_chain_loader: buffers configuration words and shifts them LSB-first
// into the Buckeye daisy chain with a divided shift clock (CLK40 domain).
// Ports:
//   CLK40, RST_N        - clock, async active-low reset
//   WR_EN, WR_DATA      - append a word (IDLE only, else ERR)
//   CLR_BUF             - empty buffer (IDLE only)
//   LOAD                - shift buffer image into the chain
//   LOAD_DFLT           - refill with default pattern, then load
//   CLR_DONE            - clear DONE, ERR, RB_ERR
//   SDO                 - chain return (read-back only)
//   BKY_ENA/SHCK/SDATA  - chain pins, registered
//   BUSY, DONE, ERR, RB_ERR, COUNT - status
// Configuration macro: BKY_READBACK_CHK_EN enables a second verify pass.
module bky_chain_loader
    import bky_pkg::*;
#(
    parameter int               WIDTH      = BKY_DFLT_WIDTH,
    parameter int               DEPTH      = BKY_DFLT_DEPTH,
    parameter int               DIV        = BKY_DFLT_DIV,
    parameter int               DFLT_WORDS = BKY_DFLT_WORDS,
    parameter logic [WIDTH-1:0] DFLT_WORD  = '0,
    parameter int               CW         = $clog2(DEPTH + 1)
) (
    input  logic             CLK40,
    input  logic             RST_N,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             CLR_BUF,
    input  logic             LOAD,
    input  logic             LOAD_DFLT,
    input  logic             CLR_DONE,
    input  logic             SDO,
    output logic             BKY_ENA,
    output logic             SHCK,
    output logic             SDATA,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic             RB_ERR,
    output logic [CW-1:0]    COUNT
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PW = (2 * DIV > 1) ? $clog2(2 * DIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FW = $clog2(DFLT_WORDS + 1);

    state_t           state, nxt;
    logic [PW-1:0]    phase, nphase;     // position inside a 2*DIV bit cell
    logic [BW-1:0]    bit_j, nbit;
    logic [AW-1:0]    word_k, nword;
    logic [0:0]       pass_q, npass;
    logic [FW-1:0]    fill_cnt, nfill;

    logic             buf_clr, buf_we, buf_full;
    logic [WIDTH-1:0] buf_wdata, rd_data;
    logic [CW-1:0]    count;

    logic             set_err, set_done, start_clr;
    logic             cell_end;
    logic             bky_ena_q, shck_q, sdata_q, done_q, err_q;

    bky_word_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .CW(CW)) u_buf (
        .clk     (CLK40),
        .rst_n   (RST_N),
        .clr     (buf_clr),
        .we      (buf_we),
        .wdata   (buf_wdata),
        .rd_idx  (nword),
        .rd_data (rd_data),
        .count   (count),
        .full    (buf_full)
    );

    assign cell_end = (phase == PW'(2 * DIV - 1));

    always_comb begin
        nxt       = state;
        nphase    = phase;
        nbit      = bit_j;
        nword     = word_k;
        npass     = pass_q;
        nfill     = fill_cnt;
        buf_clr   = 1'b0;
        buf_we    = 1'b0;
        buf_wdata = WR_DATA;
        set_err   = 1'b0;
        set_done  = 1'b0;
        start_clr = 1'b0;

        case (state)
            ST_IDLE: begin
                nphase = '0;
                nbit   = '0;
                nword  = '0;
                npass  = '0;
                nfill  = '0;
                if (WR_EN) begin
                    if (buf_full) set_err = 1'b1;
                    else          buf_we  = 1'b1;
                end
                if (LOAD_DFLT) begin
                    nxt       = ST_FILL;
                    buf_clr   = 1'b1;
                    start_clr = 1'b1;
                end else if (LOAD) begin
                    if (count != '0) begin
                        nxt       = ST_PRE;
                        start_clr = 1'b1;
                    end else begin
                        set_err = 1'b1;
                    end
                end else if (CLR_BUF) begin
                    buf_clr = 1'b1;
                end
            end
            ST_FILL: begin
                buf_we    = 1'b1;
                buf_wdata = DFLT_WORD;
                nfill     = fill_cnt + 1'b1;
                if (fill_cnt == FW'(DFLT_WORDS - 1))
                    nxt = ST_PRE;
            end
            ST_PRE: begin
                nphase = phase + 1'b1;
                if (cell_end) begin
                    nphase = '0;
                    nxt    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                nphase = phase + 1'b1;
                if (cell_end) begin
                    nphase = '0;
                    if (bit_j == BW'(WIDTH - 1)) begin
                        nbit = '0;
                        if (CW'(word_k) == count - 1'b1) begin
                            nword = '0;
                            if (pass_q == 1'(PASSES - 1)) nxt   = ST_POST;
                            else                          npass = pass_q + 1'b1;
                        end else begin
                            nword = word_k + 1'b1;
                        end
                    end else begin
                        nbit = bit_j + 1'b1;
                    end
                end
            end
            ST_POST: begin
                nphase = phase + 1'b1;
                if (cell_end) begin
                    nphase   = '0;
                    nxt      = ST_IDLE;
                    set_done = 1'b1;
                end
            end
            default: nxt = ST_IDLE;
        endcase

        // Requests arriving mid-load are dropped and flagged; CLR_BUF is
        // silently dropped.
        if (state != ST_IDLE && (LOAD || LOAD_DFLT || WR_EN))
            set_err = 1'b1;
    end

    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            phase     <= '0;
            bit_j     <= '0;
            word_k    <= '0;
            pass_q    <= '0;
            fill_cnt  <= '0;
            bky_ena_q <= 1'b0;
            shck_q    <= 1'b0;
            sdata_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= nxt;
            phase     <= nphase;
            bit_j     <= nbit;
            word_k    <= nword;
            pass_q    <= npass;
            fill_cnt  <= nfill;
            // Pins are registered from next-state values so they line up
            // with the state they describe.
            bky_ena_q <= (nxt == ST_PRE) || (nxt == ST_SHIFT) || (nxt == ST_POST);
            shck_q    <= (nxt == ST_SHIFT) && (nphase >= PW'(DIV));
            sdata_q   <= (nxt == ST_SHIFT) ? rd_data[nbit] : 1'b0;
            if (set_done)                   done_q <= 1'b1;
            else if (CLR_DONE || start_clr) done_q <= 1'b0;
            if (set_err)       err_q <= 1'b1;
            else if (CLR_DONE) err_q <= 1'b0;
        end
    end

`ifdef BKY_READBACK_CHK_EN
    logic rb_q;

    // Compare at the last CLK40 of each second-pass SHCK-high phase, when
    // the chain has had the full high phase to settle its return.
    always_ff @(posedge CLK40 or negedge RST_N) begin
        if (!RST_N)
            rb_q <= 1'b0;
        else if (state == ST_SHIFT && pass_q == 1'b1 && cell_end && SDO != sdata_q)
            rb_q <= 1'b1;
        else if (CLR_DONE)
            rb_q <= 1'b0;
    end

    assign RB_ERR = rb_q;
`else
    logic unused_sdo;
    assign unused_sdo = SDO;
    assign RB_ERR     = 1'b0;
`endif

    assign BKY_ENA = bky_ena_q;
    assign SHCK    = shck_q;
    assign SDATA   = sdata_q;
    assign BUSY    = (state != ST_IDLE);
    assign DONE    = done_q;
    assign ERR     = err_q;
    assign COUNT   = count;

endmodule

// File: tb/tb_bky_chain_loader.sv
module tb_bky_chain_loader;
    import bky_pkg::*;

    localparam int W   = 16;
    localparam int D   = 512;
    localparam int DV  = 2;
    localparam int DW  = 18;
    localparam int CWT = $clog2(D + 1);
    localparam int T1  = (2 + PASSES * 16) * 2 * DV;          // one-word load
    localparam int TD  = DW + (2 + PASSES * DW * 16) * 2 * DV; // default load

    logic           CLK40 = 0, RST_N = 0;
    logic           WR_EN = 0, CLR_BUF = 0, LOAD = 0, LOAD_DFLT = 0, CLR_DONE = 0;
    logic           SDO = 0;
    logic [W-1:0]   WR_DATA = '0;
    logic           BKY_ENA, SHCK, SDATA, BUSY, DONE, ERR, RB_ERR;
    logic [CWT-1:0] COUNT;

    int   nchk = 0, nfail = 0;
    int   rise_cnt = 0;
    int   flip_at = -1;
    logic sent [4096];
    logic exp_a5c3 [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};

    bky_chain_loader #(.WIDTH(W), .DEPTH(D), .DIV(DV), .DFLT_WORDS(DW), .DFLT_WORD('0)) dut (
        .CLK40(CLK40), .RST_N(RST_N), .WR_EN(WR_EN), .WR_DATA(WR_DATA),
        .CLR_BUF(CLR_BUF), .LOAD(LOAD), .LOAD_DFLT(LOAD_DFLT), .CLR_DONE(CLR_DONE),
        .SDO(SDO), .BKY_ENA(BKY_ENA), .SHCK(SHCK), .SDATA(SDATA), .BUSY(BUSY),
        .DONE(DONE), .ERR(ERR), .RB_ERR(RB_ERR), .COUNT(COUNT)
    );

    always #5 CLK40 = ~CLK40;

    // Chain model: record every bit sampled on SHCK rise; SDO returns the
    // bit sampled 16 rises earlier, optionally corrupted at one rise.
    always @(posedge SHCK) begin
        sent[rise_cnt % 4096] <= SDATA;
        SDO <= ((rise_cnt >= 16) ? sent[(rise_cnt - 16) % 4096] : 1'b0) ^ (rise_cnt == flip_at);
        rise_cnt <= rise_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK40);
        #1;
    endtask

    task automatic wait_done(input int maxc, output int n);
        n = 0;
        while (n < maxc) begin
            tick();
            n++;
            if (DONE) break;
        end
    endtask

    task automatic write_word(input logic [W-1:0] d);
        WR_DATA = d; WR_EN = 1; tick(); WR_EN = 0;
    endtask

    task automatic pulse_clr_done();
        CLR_DONE = 1; tick(); CLR_DONE = 0;
    endtask

    task automatic test_reset();
        RST_N = 0;
        #2;
        nchk++;
        if ({BKY_ENA, SHCK, SDATA, BUSY, DONE, ERR, RB_ERR} !== 7'b0) begin
            nfail++; $display("FAIL reset_outputs got=%b want=0000000", {BKY_ENA, SHCK, SDATA, BUSY, DONE, ERR, RB_ERR});
        end
        nchk++;
        if (COUNT !== '0) begin nfail++; $display("FAIL reset_count got=%0d want=0", COUNT); end
        #10 RST_N = 1;
        tick(); tick();
    endtask

    task automatic test_single_word();
        int n, base;
        write_word(16'hA5C3);
        nchk++;
        if (COUNT !== CWT'(1)) begin nfail++; $display("FAIL single_count got=%0d want=1", COUNT); end
        base = rise_cnt;
        LOAD = 1; tick(); LOAD = 0;
        nchk++;
        if ({BUSY, BKY_ENA, SHCK} !== 3'b110) begin nfail++; $display("FAIL single_start got=%b want=110", {BUSY, BKY_ENA, SHCK}); end
        wait_done(5000, n);
        nchk++;
        if (n !== T1) begin nfail++; $display("FAIL single_latency got=%0d want=%0d", n, T1); end
        nchk++;
        if ({DONE, BUSY, BKY_ENA, ERR} !== 4'b1000) begin nfail++; $display("FAIL single_end got=%b want=1000", {DONE, BUSY, BKY_ENA, ERR}); end
        nchk++;
        if (rise_cnt - base !== PASSES * 16) begin nfail++; $display("FAIL single_rises got=%0d want=%0d", rise_cnt - base, PASSES * 16); end
        for (int p = 0; p < PASSES; p++)
            for (int i = 0; i < 16; i++) begin
                nchk++;
                if (sent[(base + p * 16 + i) % 4096] !== exp_a5c3[i]) begin
                    nfail++; $display("FAIL single_bit p%0d b%0d got=%b want=%b", p, i, sent[(base + p * 16 + i) % 4096], exp_a5c3[i]);
                end
            end
    endtask

    task automatic test_default();
        int n, base, ones;
        pulse_clr_done();
        base = rise_cnt;
        LOAD_DFLT = 1; tick(); LOAD_DFLT = 0;
        nchk++;
        if ({BUSY, DONE} !== 2'b10) begin nfail++; $display("FAIL dflt_start got=%b want=10", {BUSY, DONE}); end
        wait_done(10000, n);
        nchk++;
        if (n !== TD) begin nfail++; $display("FAIL dflt_latency got=%0d want=%0d", n, TD); end
        nchk++;
        if (COUNT !== CWT'(DW)) begin nfail++; $display("FAIL dflt_count got=%0d want=%0d", COUNT, DW); end
        nchk++;
        if ({DONE, ERR} !== 2'b10) begin nfail++; $display("FAIL dflt_flags got=%b want=10", {DONE, ERR}); end
        nchk++;
        if (rise_cnt - base !== PASSES * DW * 16) begin nfail++; $display("FAIL dflt_rises got=%0d want=%0d", rise_cnt - base, PASSES * DW * 16); end
        ones = 0;
        for (int i = 0; i < PASSES * DW * 16; i++) if (sent[(base + i) % 4096] !== 1'b0) ones++;
        nchk++;
        if (ones !== 0) begin nfail++; $display("FAIL dflt_data nonzero_bits=%0d want=0", ones); end
    endtask

    task automatic test_overflow();
        CLR_DONE = 1; CLR_BUF = 1; tick(); CLR_DONE = 0; CLR_BUF = 0;
        for (int i = 0; i < D; i++) write_word(W'(i));
        nchk++;
        if ({COUNT, ERR} !== {CWT'(D), 1'b0}) begin nfail++; $display("FAIL full_count got=%0d err=%b want=%0d err=0", COUNT, ERR, D); end
        write_word(16'hFFFF);
        nchk++;
        if ({COUNT, ERR} !== {CWT'(D), 1'b1}) begin nfail++; $display("FAIL overflow got=%0d err=%b want=%0d err=1", COUNT, ERR, D); end
        pulse_clr_done();
        nchk++;
        if (ERR !== 1'b0) begin nfail++; $display("FAIL overflow_clr got=%b want=0", ERR); end
        CLR_BUF = 1; tick(); CLR_BUF = 0;
        nchk++;
        if (COUNT !== '0) begin nfail++; $display("FAIL clr_buf got=%0d want=0", COUNT); end
        LOAD = 1; tick(); LOAD = 0;
        nchk++;
        if ({BKY_ENA, BUSY, ERR} !== 3'b001) begin nfail++; $display("FAIL empty_load got=%b want=001", {BKY_ENA, BUSY, ERR}); end
        tick(); tick();
        nchk++;
        if ({BKY_ENA, BUSY} !== 2'b00) begin nfail++; $display("FAIL empty_load_idle got=%b want=00", {BKY_ENA, BUSY}); end
    endtask

    task automatic test_reset_midload();
        int n, base, guard;
        pulse_clr_done();
        write_word(16'hA5C3);
        base = rise_cnt;
        LOAD = 1; tick(); LOAD = 0;
        guard = 0;
        while (rise_cnt - base < 6 && guard < 2000) begin tick(); guard++; end
        nchk++;
        if (rise_cnt - base !== 6) begin nfail++; $display("FAIL midload_reach got=%0d want=6", rise_cnt - base); end
        #2 RST_N = 0;
        #1;
        nchk++;
        if ({BKY_ENA, SHCK, SDATA, BUSY, DONE, ERR, RB_ERR} !== 7'b0) begin
            nfail++; $display("FAIL midload_outputs got=%b want=0000000", {BKY_ENA, SHCK, SDATA, BUSY, DONE, ERR, RB_ERR});
        end
        nchk++;
        if (COUNT !== '0) begin nfail++; $display("FAIL midload_count got=%0d want=0", COUNT); end
        #2 RST_N = 1;
        tick();
        write_word(16'hA5C3);
        base = rise_cnt;
        LOAD = 1; tick(); LOAD = 0;
        wait_done(5000, n);
        nchk++;
        if (n !== T1) begin nfail++; $display("FAIL reload_latency got=%0d want=%0d", n, T1); end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (sent[(base + i) % 4096] !== exp_a5c3[i]) begin
                nfail++; $display("FAIL reload_bit b%0d got=%b want=%b", i, sent[(base + i) % 4096], exp_a5c3[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        pulse_clr_done();
        base = rise_cnt;
        LOAD = 1; tick(); LOAD = 0;
        tick(); tick(); tick();
        LOAD = 1; tick(); LOAD = 0;
        nchk++;
        if ({BUSY, ERR} !== 2'b11) begin nfail++; $display("FAIL busy_load got=%b want=11", {BUSY, ERR}); end
        LOAD_DFLT = 1; tick(); LOAD_DFLT = 0;
        nchk++;
        if ({COUNT, ERR} !== {CWT'(1), 1'b1}) begin nfail++; $display("FAIL busy_dflt count=%0d err=%b want 1/1", COUNT, ERR); end
        for (int i = 6; i < T1; i++) tick();
        nchk++;
        if ({DONE, BUSY} !== 2'b01) begin nfail++; $display("FAIL pre_done got=%b want=01", {DONE, BUSY}); end
        CLR_DONE = 1; tick(); CLR_DONE = 0;
        nchk++;
        if ({DONE, ERR, BUSY} !== 3'b100) begin nfail++; $display("FAIL done_clr_coinc got=%b want=100", {DONE, ERR, BUSY}); end
        nchk++;
        if (rise_cnt - base !== PASSES * 16) begin nfail++; $display("FAIL b2b_rises got=%0d want=%0d", rise_cnt - base, PASSES * 16); end
        for (int i = 0; i < 16; i++) begin
            nchk++;
            if (sent[(base + i) % 4096] !== exp_a5c3[i]) begin
                nfail++; $display("FAIL b2b_bit b%0d got=%b want=%b", i, sent[(base + i) % 4096], exp_a5c3[i]);
            end
        end
        pulse_clr_done();
        nchk++;
        if (DONE !== 1'b0) begin nfail++; $display("FAIL clr_done got=%b want=0", DONE); end
    endtask

    task automatic test_readback();
        int n, base;
        logic rb_exp;
        rb_exp = (PASSES == 2);
        flip_at = -1;
        LOAD = 1; tick(); LOAD = 0;
        wait_done(5000, n);
        nchk++;
        if (RB_ERR !== 1'b0) begin nfail++; $display("FAIL rb_clean got=%b want=0", RB_ERR); end
        pulse_clr_done();
        base = rise_cnt;
        flip_at = base + 16 + 3;
        LOAD = 1; tick(); LOAD = 0;
        wait_done(5000, n);
        flip_at = -1;
        nchk++;
        if (RB_ERR !== rb_exp) begin nfail++; $display("FAIL rb_flip got=%b want=%b", RB_ERR, rb_exp); end
        nchk++;
        if ({DONE, n == T1} !== 2'b11) begin nfail++; $display("FAIL rb_done done=%b cycles=%0d want 1/%0d", DONE, n, T1); end
        pulse_clr_done();
        nchk++;
        if (RB_ERR !== 1'b0) begin nfail++; $display("FAIL rb_clear got=%b want=0", RB_ERR); end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_default();
        test_overflow();
        test_reset_midload();
        test_back_to_back();
        test_readback();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
